// File: rtl/odesa_pkg.sv
// Shared definitions for the layer-1 trace generator: trace defaults,
// label-activation FSM encoding and the packed trace bus slice helper.
package odesa_pkg;

    localparam int TR_WIDTH = 9;
    localparam int TR_INIT  = 63;

    typedef enum logic [1:0] {
        LAS_IDLE  = 2'd0,
        LAS_WAIT  = 2'd1,
        LAS_PULSE = 2'd2
    } las_state_t;

    // Lowest bit of channel ch inside a bus of width-bit slices.
    function automatic int tr_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/trace_cell.sv
// One trace channel: spike rising-edge detect, linearly decaying counter,
// active flag and the registered trace output.
module trace_cell
    import odesa_pkg::*;
#(
    parameter int p_width = TR_WIDTH,
    parameter int p_init  = TR_INIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spike,
    output logic               rise,
    input  logic               load,
    input  logic               kill,
    input  logic               tick,
    input  logic               clr,
    output logic [p_width-1:0] tr,
    output logic               active
);

    localparam logic [p_width-1:0] INIT = p_width'(p_init);
    localparam logic [p_width-1:0] LAST = p_width'(2);

    logic               spike_prev;
    logic [p_width-1:0] count;
    logic [p_width-1:0] count_nxt;
    logic               active_nxt;

    assign rise = spike & ~spike_prev;

    always_comb begin
        count_nxt  = count;
        active_nxt = active;
        if (clr || kill) begin
            count_nxt  = INIT;
            active_nxt = 1'b0;
        end else if (load) begin
            count_nxt  = INIT;
            active_nxt = 1'b1;
        end else if (tick && active) begin
            // Retire instead of stepping to 1, so the last visible value is 2.
            if (count <= LAST) begin
                count_nxt  = INIT;
                active_nxt = 1'b0;
            end else begin
                count_nxt = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_prev <= 1'b0;
            count      <= INIT;
            active     <= 1'b0;
            tr         <= '0;
        end else begin
            spike_prev <= spike;
            count      <= count_nxt;
            active     <= active_nxt;
            tr         <= active_nxt ? count_nxt : '0;
        end
    end

endmodule

// File: rtl/l1_trace_gen.sv
// Layer-1 trace generator: per-neuron decaying traces with optional
// one-at-a-time arbitration, plus a delayed label-activation pulse.
module l1_trace_gen
    import odesa_pkg::*;
#(
    parameter int p_n_ch      = 2,
    parameter int p_width     = TR_WIDTH,
    parameter int p_init      = TR_INIT,
    parameter int p_latency   = 5,
    parameter int p_exclusive = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_tick,
    input  logic [p_n_ch-1:0]           i_spike,
    input  logic                        i_clr,
    output logic [p_n_ch*p_width-1:0]   o_tr,
    output logic [p_n_ch-1:0]           o_active,
    output logic                        o_las
);

    logic [p_n_ch-1:0] rise;
    logic [p_n_ch-1:0] load;
    logic [p_n_ch-1:0] kill;
    logic              found;

    las_state_t        state;
    las_state_t        state_nxt;
    logic [3:0]        delay;
    logic [3:0]        delay_nxt;

    // In exclusive mode only the lowest-index edge is accepted.
    always_comb begin
        load  = '0;
        found = 1'b0;
        for (int n = 0; n < p_n_ch; n++) begin
            if (rise[n] && (!found || p_exclusive == 0)) begin
                load[n] = 1'b1;
                found   = 1'b1;
            end
        end
        kill = (p_exclusive != 0 && found) ? ~load : '0;
    end

    for (genvar n = 0; n < p_n_ch; n++) begin : g_ch
        localparam int LSB = tr_lsb(n, p_width);
        trace_cell #(
            .p_width (p_width),
            .p_init  (p_init)
        ) u_cell (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .spike  (i_spike[n]),
            .rise   (rise[n]),
            .load   (load[n]),
            .kill   (kill[n]),
            .tick   (i_tick),
            .clr    (i_clr),
            .tr     (o_tr[LSB +: p_width]),
            .active (o_active[n])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= LAS_IDLE;
            delay <= '0;
        end else begin
            state <= state_nxt;
            delay <= delay_nxt;
        end
    end

    // Edges seen outside IDLE are dropped: one pulse per window.
    always_comb begin
        state_nxt = state;
        delay_nxt = delay;
        if (i_clr) begin
            state_nxt = LAS_IDLE;
            delay_nxt = '0;
        end else begin
            case (state)
                LAS_IDLE: begin
                    if (found) begin
                        state_nxt = LAS_WAIT;
                        delay_nxt = 4'(p_latency);
                    end
                end
                LAS_WAIT: begin
                    if (i_tick) begin
                        if (delay == 4'd0) state_nxt = LAS_PULSE;
                        else               delay_nxt = delay - 4'd1;
                    end
                end
                LAS_PULSE: begin
                    if (i_tick) state_nxt = LAS_IDLE;
                end
                default: state_nxt = LAS_IDLE;
            endcase
        end
    end

    always_comb begin
        o_las = (state == LAS_PULSE);
    end

endmodule

// File: tb/tb_l1_trace_gen.sv
// Directed bench for l1_trace_gen: exclusive and non-exclusive instances
// checked every cycle against a trace-value model, plus literal spot checks.
module tb_l1_trace_gen;

    localparam int INIT = 63;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  spike = 2'b00;

    logic [17:0] tr_x, tr_n;
    logic [1:0]  act_x, act_n;
    logic        las_x, las_n;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    l1_trace_gen #(.p_n_ch(2), .p_width(9), .p_init(INIT), .p_latency(LAT), .p_exclusive(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_spike(spike), .i_clr(clr),
        .o_tr(tr_x), .o_active(act_x), .o_las(las_x));

    l1_trace_gen #(.p_n_ch(2), .p_width(9), .p_init(INIT), .p_latency(LAT), .p_exclusive(0)) dut_ne (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_spike(spike), .i_clr(clr),
        .o_tr(tr_n), .o_active(act_n), .o_las(las_n));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: trace value per channel (0 = inactive), las as ticks-to-pulse.
    // Index k: 0 = exclusive instance, 1 = non-exclusive instance.
    logic [1:0] m_prev;
    logic [8:0] m_tr [2][2];
    int         m_mode [2];   // 0 idle, 1 waiting, 2 pulsing
    int         m_wait [2];
    logic [1:0] m_edges, m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0;
                m_wait[k] = 0;
                for (int n = 0; n < 2; n++) m_tr[k][n] = 9'd0;
            end
        end else begin
            m_edges = spike & ~m_prev;
            m_prev  = spike;
            for (int k = 0; k < 2; k++) begin
                m_acc = (k == 0) ? (m_edges & (~m_edges + 2'd1)) : m_edges;
                if (clr) begin
                    m_mode[k] = 0;
                    for (int n = 0; n < 2; n++) m_tr[k][n] = 9'd0;
                end else begin
                    for (int n = 0; n < 2; n++) begin
                        if (m_acc[n])                     m_tr[k][n] = 9'(INIT);
                        else if (k == 0 && m_acc != 2'b0) m_tr[k][n] = 9'd0;
                        else if (tick && m_tr[k][n] != 0)
                            m_tr[k][n] = (m_tr[k][n] == 9'd2) ? 9'd0 : m_tr[k][n] - 9'd1;
                    end
                    if (m_mode[k] == 0) begin
                        if (m_acc != 2'b0) begin
                            m_mode[k] = 1;
                            m_wait[k] = LAT + 1;
                        end
                    end else if (tick) begin
                        if (m_mode[k] == 1) begin
                            m_wait[k]--;
                            if (m_wait[k] == 0) m_mode[k] = 2;
                        end else begin
                            m_mode[k] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_tr_x",  tr_x,  {m_tr[0][1], m_tr[0][0]});
            check("cmp_act_x", act_x, {m_tr[0][1] != 0, m_tr[0][0] != 0});
            check("cmp_las_x", las_x, m_mode[0] == 2);
            check("cmp_tr_n",  tr_n,  {m_tr[1][1], m_tr[1][0]});
            check("cmp_act_n", act_n, {m_tr[1][1] != 0, m_tr[1][0] != 0});
            check("cmp_las_n", las_n, m_mode[1] == 2);
        end
    end

    int   rises_x = 0, rises_n = 0;
    logic lx_q = 1'b0, ln_q = 1'b0;
    always @(negedge clk) begin
        if (las_x && !lx_q) rises_x++;
        if (las_n && !ln_q) rises_n++;
        lx_q = las_x;
        ln_q = las_n;
    end

    task automatic do_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic ticks(input int cnt);
        repeat (cnt) do_tick();
    endtask

    task automatic pulse(input logic [1:0] v);
        @(negedge clk); spike = v;
        @(negedge clk); spike = 2'b00;
    endtask

    task automatic apply_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    int base_x, base_n;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_tr", tr_x, 0);
        check("rst_act", act_x, 0);
        check("rst_las", las_x, 0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Single spike on ch1, ticks every 16 cycles
        @(negedge clk); spike = 2'b01;
        @(negedge clk);
        check("t1_load", tr_x[8:0], 63);
        @(negedge clk); spike = 2'b00;
        for (int t = 1; t <= 62; t++) begin
            repeat (14) @(negedge clk);
            do_tick();
            if (t == 5)  check("t1_las_before", las_x, 0);
            if (t == 6)  check("t1_las_on", las_x, 1);
            if (t == 7)  check("t1_las_off", las_x, 0);
            if (t == 61) check("t1_last", tr_x[8:0], 2);
            if (t == 62) begin
                check("t1_end_tr", tr_x[8:0], 0);
                check("t1_end_act", act_x, 0);
            end
        end

        // Retrigger on ch2
        apply_reset();
        base_x = rises_x;
        pulse(2'b10);
        ticks(10);
        check("rt_53", tr_x[17:9], 53);
        check("rt_first_las", rises_x - base_x, 1);
        pulse(2'b10);
        check("rt_reload", tr_x[17:9], 63);
        ticks(3);
        pulse(2'b10);
        check("rt_reload2", tr_x[17:9], 63);
        ticks(10);
        check("rt_after", tr_x[17:9], 53);
        check("rt_las_count", rises_x - base_x, 2);

        // Exclusive handoff
        apply_reset();
        pulse(2'b01);
        ticks(23);
        check("ex_40", tr_x[8:0], 40);
        pulse(2'b10);
        check("ex_ch1", tr_x[8:0], 0);
        check("ex_act", act_x, 2'b10);
        check("ex_ch2", tr_x[17:9], 63);
        check("ex_ne", tr_n, {9'd63, 9'd40});

        // Simultaneous edges
        apply_reset();
        pulse(2'b11);
        check("sim_x", tr_x, {9'd0, 9'd63});
        check("sim_act", act_x, 2'b01);
        check("sim_ne", tr_n, {9'd63, 9'd63});

        // Tick/load collision
        ticks(5);
        check("col_pre", tr_x[8:0], 58);
        @(negedge clk); spike = 2'b01; tick = 1'b1;
        @(negedge clk); spike = 2'b00; tick = 1'b0;
        check("col_x", tr_x[8:0], 63);
        check("col_ne", tr_n, {9'd57, 9'd63});

        // Async reset during WAIT with a live trace of 30
        apply_reset();
        pulse(2'b01);
        ticks(33);
        pulse(2'b10);
        check("rs_30", tr_n[8:0], 30);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("rs_tr_x", tr_x, 0);
        check("rs_tr_n", tr_n, 0);
        check("rs_act", {act_x, act_n}, 0);
        check("rs_las", {las_x, las_n}, 0);
        base_x = rises_x;
        base_n = rises_n;
        @(negedge clk); #2 rst_n = 1'b1;
        ticks(10);
        check("rs_no_las", (rises_x - base_x) + (rises_n - base_n), 0);

        // Synchronous clear with a coincident ch1 edge
        pulse(2'b01);
        ticks(33);
        pulse(2'b10);
        base_x = rises_x;
        base_n = rises_n;
        @(negedge clk); clr = 1'b1; spike = 2'b01;
        @(negedge clk); clr = 1'b0;
        check("clr_tr", {tr_x, tr_n}, 0);
        check("clr_act", {act_x, act_n}, 0);
        check("clr_las", {las_x, las_n}, 0);
        @(negedge clk); spike = 2'b00;
        ticks(10);
        check("clr_no_las", (rises_x - base_x) + (rises_n - base_n), 0);
        check("clr_no_trace", {tr_x, tr_n}, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
